// File: rtl/cla_pipe_adder_if.sv
// Handshake bus for the pipelined carry-lookahead adder. The master
// drives operands and out_ready; the slave (the adder) returns in_ready
// and the registered result fields.
interface cla_pipe_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             p_out;
  logic             g_out;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, p_out, g_out, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, p_out, g_out, ovf
  );
endinterface

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder with valid/ready handshake.
// Stage 1 registers operands plus per-bit and per-group propagate/generate
// terms; stage 2 resolves group carries, in-group carries and the result
// flags, then registers them into the output stage. Capacity is two
// transactions; in_ready is the only output that is combinational.
module cla_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input logic           clk,
  input logic           rst_n,
  cla_pipe_adder_if.slave bus
);

  // WIDTH must be a multiple of GROUP; GROUP is 2, 4 or 8.
  localparam int NG = WIDTH / GROUP;

  // Generate of one group with zero carry in (ripple-lookahead form).
  function automatic logic grp_gen(input logic [GROUP-1:0] p,
                                   input logic [GROUP-1:0] g);
    logic acc;
    acc = 1'b0;
    for (int j = 0; j < GROUP; j++) acc = g[j] | (p[j] & acc);
    return acc;
  endfunction

  // Carry into each bit of one group, given the group's carry in.
  function automatic logic [GROUP-1:0] grp_carries(input logic [GROUP-1:0] p,
                                                   input logic [GROUP-1:0] g,
                                                   input logic             c_in);
    logic [GROUP-1:0] c;
    logic             run;
    run = c_in;
    for (int j = 0; j < GROUP; j++) begin
      c[j] = run;
      run  = g[j] | (p[j] & run);
    end
    return c;
  endfunction

  // Two's-complement overflow from the sign bits: operands agree in sign
  // and the result disagrees. Equivalent to carry-into-MSB ^ carry-out.
  function automatic logic ovf_fn(input logic a_msb, input logic b_msb,
                                  input logic s_msb);
    return (a_msb ~^ b_msb) & (s_msb ^ a_msb);
  endfunction

  // Stage 0 (combinational from inputs)
  logic [WIDTH-1:0] p_p0, g_p0;
  logic [NG-1:0]    gp_p0, gg_p0;

  // Stage 1 registers
  logic [WIDTH-1:0] a_p1_q, a_p1_d, b_p1_q, b_p1_d;
  logic [WIDTH-1:0] p_p1_q, p_p1_d, g_p1_q, g_p1_d;
  logic [NG-1:0]    gp_p1_q, gp_p1_d, gg_p1_q, gg_p1_d;
  logic             cin_p1_q, cin_p1_d;
  logic             vld_p1_q, vld_p1_d;

  // Stage 2 combinational resolution
  logic [NG:0]      c_grp, z_grp;
  logic [WIDTH-1:0] carry_p1, sum_p1;

  // Output stage registers
  logic [WIDTH-1:0] sum_p2_q, sum_p2_d;
  logic             cout_p2_q, cout_p2_d;
  logic             pout_p2_q, pout_p2_d;
  logic             gout_p2_q, gout_p2_d;
  logic             ovf_p2_q, ovf_p2_d;
  logic             vld_p2_q, vld_p2_d;

  // Handshake
  logic out_adv, xfer, in_ready_c, accept;

  // Per-bit and per-group propagate/generate from the raw operands.
  always_comb begin
    p_p0  = bus.a ^ bus.b;
    g_p0  = bus.a & bus.b;
    gp_p0 = '0;
    gg_p0 = '0;
    for (int k = 0; k < NG; k++) begin
      gp_p0[k] = &p_p0[k*GROUP +: GROUP];
      gg_p0[k] = grp_gen(p_p0[k*GROUP +: GROUP], g_p0[k*GROUP +: GROUP]);
    end
  end

  // Handshake: output advances when empty or consumed; S1 accepts when
  // empty or able to move on this edge.
  always_comb begin
    out_adv    = !vld_p2_q | bus.out_ready;
    xfer       = vld_p1_q & out_adv;
    in_ready_c = !vld_p1_q | out_adv;
    accept     = bus.in_valid & in_ready_c;
  end

  assign bus.in_ready = in_ready_c;

  // Stage 1 next state: capture on accept, otherwise hold.
  always_comb begin
    a_p1_d   = accept ? bus.a   : a_p1_q;
    b_p1_d   = accept ? bus.b   : b_p1_q;
    cin_p1_d = accept ? bus.cin : cin_p1_q;
    p_p1_d   = accept ? p_p0    : p_p1_q;
    g_p1_d   = accept ? g_p0    : g_p1_q;
    gp_p1_d  = accept ? gp_p0   : gp_p1_q;
    gg_p1_d  = accept ? gg_p0   : gg_p1_q;
    vld_p1_d = accept | (vld_p1_q & !xfer);
  end

  // ---- stage 1 / stage 2 boundary ----
  // Group carries (with real cin and with cin=0 for g_out), then the
  // in-group bit carries and the sum.
  always_comb begin
    c_grp    = '0;
    z_grp    = '0;
    carry_p1 = '0;
    c_grp[0] = cin_p1_q;
    for (int k = 0; k < NG; k++) begin
      c_grp[k+1] = gg_p1_q[k] | (gp_p1_q[k] & c_grp[k]);
      z_grp[k+1] = gg_p1_q[k] | (gp_p1_q[k] & z_grp[k]);
      carry_p1[k*GROUP +: GROUP] = grp_carries(p_p1_q[k*GROUP +: GROUP],
                                               g_p1_q[k*GROUP +: GROUP],
                                               c_grp[k]);
    end
    sum_p1 = p_p1_q ^ carry_p1;
  end

  // Output stage next state: load on transfer, otherwise hold stable.
  always_comb begin
    sum_p2_d  = xfer ? sum_p1    : sum_p2_q;
    cout_p2_d = xfer ? c_grp[NG] : cout_p2_q;
    pout_p2_d = xfer ? &gp_p1_q  : pout_p2_q;
    gout_p2_d = xfer ? z_grp[NG] : gout_p2_q;
    ovf_p2_d  = xfer ? ovf_fn(a_p1_q[WIDTH-1], b_p1_q[WIDTH-1], sum_p1[WIDTH-1])
                     : ovf_p2_q;
    vld_p2_d  = xfer | (vld_p2_q & !bus.out_ready);
  end

  // Pipeline registers; asynchronous reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_p1_q    <= '0;
      b_p1_q    <= '0;
      cin_p1_q  <= 1'b0;
      p_p1_q    <= '0;
      g_p1_q    <= '0;
      gp_p1_q   <= '0;
      gg_p1_q   <= '0;
      vld_p1_q  <= 1'b0;
      sum_p2_q  <= '0;
      cout_p2_q <= 1'b0;
      pout_p2_q <= 1'b0;
      gout_p2_q <= 1'b0;
      ovf_p2_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
    end else begin
      a_p1_q    <= a_p1_d;
      b_p1_q    <= b_p1_d;
      cin_p1_q  <= cin_p1_d;
      p_p1_q    <= p_p1_d;
      g_p1_q    <= g_p1_d;
      gp_p1_q   <= gp_p1_d;
      gg_p1_q   <= gg_p1_d;
      vld_p1_q  <= vld_p1_d;
      sum_p2_q  <= sum_p2_d;
      cout_p2_q <= cout_p2_d;
      pout_p2_q <= pout_p2_d;
      gout_p2_q <= gout_p2_d;
      ovf_p2_q  <= ovf_p2_d;
      vld_p2_q  <= vld_p2_d;
    end
  end

  // ---- stage 2 / output boundary ----
  assign bus.out_valid = vld_p2_q;
  assign bus.sum       = sum_p2_q;
  assign bus.cout      = cout_p2_q;
  assign bus.p_out     = pout_p2_q;
  assign bus.g_out     = gout_p2_q;
  assign bus.ovf       = ovf_p2_q;

endmodule
